ch0re_alu_sched: RTL and testbench

//  Shares the single combinational ALU between two requesters: port 0 (execute stage) and port 1 (branch/aux unit).

---
 rtl/ch0re_types.sv | 24 ++
 rtl/ch0re_arb2.sv | 74 +++++++
 rtl/ch0re_alu_sched.sv | 112 +++++++++++
 tb/tb_ch0re_alu_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ch0re_types.sv
// Shared types for the ch0re ALU path: ALU opcodes, scheduler state and requester id.
package ch0re_types;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } alu_sched_state_e;

   typedef logic alu_req_id_t;

endpackage

// File: rtl/ch0re_arb2.sv
// Two-way grant logic for the ALU scheduler. Round-robin when CH0RE_ALU_SCHED_RR_EN is
// defined, otherwise fixed priority (port 0) with a starvation counter protecting port 1.
module ch0re_arb2
   import ch0re_types::*;
#(
   parameter int unsigned STARVE_LIMIT = 7
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] valid,
   input  logic       can_issue,
   output logic [1:0] grant
);

`ifdef CH0RE_ALU_SCHED_RR_EN
   alu_req_id_t ptr_q, ptr_d;

   always_comb begin
      grant = 2'b00;
      ptr_d = ptr_q;
      if (can_issue) begin
         if (valid[0] && valid[1]) begin
            grant = ptr_q ? 2'b10 : 2'b01;
         end else begin
            grant = valid;
         end
      end
      // Only a win by the preferred port hands preference to the other side.
      if (grant[ptr_q]) begin
         ptr_d = ~ptr_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

   logic [2:0] starve_q, starve_d;
   logic       force_p1;

   always_comb begin
      grant    = 2'b00;
      starve_d = starve_q;
      force_p1 = (starve_q >= STARVE_MAX);
      if (can_issue) begin
         if (valid[1] && (force_p1 || !valid[0])) begin
            grant = 2'b10;
         end else if (valid[0]) begin
            grant = 2'b01;
         end
      end
      if (grant[1]) begin
         starve_d = 3'd0;
      end else if (can_issue && valid[1]) begin
         starve_d = starve_q + 3'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         starve_q <= 3'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`endif

endmodule

// File: rtl/ch0re_alu_sched.sv
// Shares one combinational ALU between the execute port (0) and branch/aux port (1).
// Arbitration mode is chosen by CH0RE_ALU_SCHED_RR_EN (see ch0re_arb2).
module ch0re_alu_sched
   import ch0re_types::*;
#(
   parameter int unsigned WIDTH        = 64,
   parameter int unsigned TAG_W        = 4,
   parameter int unsigned STARVE_LIMIT = 7
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req0_valid,
   output logic              o_req0_ready,
   input  alu_op_e           i_req0_op,
   input  logic [WIDTH-1:0]  i_req0_s1,
   input  logic [WIDTH-1:0]  i_req0_s2,
   input  logic [TAG_W-1:0]  i_req0_tag,
   input  logic              i_req1_valid,
   output logic              o_req1_ready,
   input  alu_op_e           i_req1_op,
   input  logic [WIDTH-1:0]  i_req1_s1,
   input  logic [WIDTH-1:0]  i_req1_s2,
   input  logic [TAG_W-1:0]  i_req1_tag,
   output alu_op_e           o_alu_op,
   output logic [WIDTH-1:0]  o_alu_s1,
   output logic [WIDTH-1:0]  o_alu_s2,
   input  logic [WIDTH-1:0]  i_alu_res,
   input  logic              i_alu_cond_hit,
   input  logic              i_alu_overflow,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [WIDTH-1:0]  o_rsp_res,
   output logic              o_rsp_cond_hit,
   output logic              o_rsp_overflow,
   output alu_req_id_t       o_rsp_id,
   output logic [TAG_W-1:0]  o_rsp_tag
);

   alu_sched_state_e state_q, state_d;
   logic             can_issue;
   logic [1:0]       grant;

   // Reset masks issue so no ready is raised while i_rst is high.
   assign can_issue = ((state_q == S_EMPTY) || i_rsp_ready) && !i_rst;

   ch0re_arb2 #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_arb (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .valid    ({i_req1_valid, i_req0_valid}),
      .can_issue(can_issue),
      .grant    (grant)
   );

   assign o_req0_ready = grant[0];
   assign o_req1_ready = grant[1];
   assign o_rsp_valid  = (state_q == S_FULL);

   always_comb begin
      o_alu_op = ALU_ADD;
      o_alu_s1 = '0;
      o_alu_s2 = '0;
      unique case (grant)
         2'b01: begin
            o_alu_op = i_req0_op;
            o_alu_s1 = i_req0_s1;
            o_alu_s2 = i_req0_s2;
         end
         2'b10: begin
            o_alu_op = i_req1_op;
            o_alu_s1 = i_req1_s1;
            o_alu_s2 = i_req1_s2;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (|grant) begin
         state_d = S_FULL;
      end else if (i_rsp_ready) begin
         state_d = S_EMPTY;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rsp_res      <= '0;
         o_rsp_cond_hit <= 1'b0;
         o_rsp_overflow <= 1'b0;
         o_rsp_id       <= 1'b0;
         o_rsp_tag      <= '0;
      end else if (|grant) begin
         o_rsp_res      <= i_alu_res;
         o_rsp_cond_hit <= i_alu_cond_hit;
         o_rsp_overflow <= i_alu_overflow;
         o_rsp_id       <= grant[1];
         o_rsp_tag      <= grant[1] ? i_req1_tag : i_req0_tag;
      end
   end

endmodule

// File: tb/tb_ch0re_alu_sched.sv
// Directed self-checking bench for ch0re_alu_sched; expectations follow CH0RE_ALU_SCHED_RR_EN.
module tb_ch0re_alu_sched;
   import ch0re_types::*;

   localparam int unsigned W  = 64;
   localparam int unsigned TW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          v0, v1, rdy0, rdy1, rsp_ready;
   alu_op_e       op0, op1, alu_op;
   logic [W-1:0]  s10, s20, s11, s21, alu_s1, alu_s2, alu_res, rsp_res;
   logic [TW-1:0] tag0, tag1, rsp_tag;
   logic          alu_cond, alu_ovf, rsp_valid, rsp_cond, rsp_ovf;
   alu_req_id_t   rsp_id;
   logic [1:0]    rdy;
   logic [W:0]    wide;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;
   assign rdy = {rdy1, rdy0};

   // Reference ALU: carry-out as overflow, unsigned less-than as cond hit.
   always_comb begin
      wide = '0;
      case (alu_op)
         ALU_ADD: wide = {1'b0, alu_s1} + {1'b0, alu_s2};
         ALU_SUB: wide = {1'b0, alu_s1} - {1'b0, alu_s2};
         default: wide = {1'b0, alu_s1 ^ alu_s2};
      endcase
   end
   assign alu_res  = wide[W-1:0];
   assign alu_ovf  = wide[W];
   assign alu_cond = (alu_s1 < alu_s2);

   ch0re_alu_sched dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req0_valid  (v0),
      .o_req0_ready  (rdy0),
      .i_req0_op     (op0),
      .i_req0_s1     (s10),
      .i_req0_s2     (s20),
      .i_req0_tag    (tag0),
      .i_req1_valid  (v1),
      .o_req1_ready  (rdy1),
      .i_req1_op     (op1),
      .i_req1_s1     (s11),
      .i_req1_s2     (s21),
      .i_req1_tag    (tag1),
      .o_alu_op      (alu_op),
      .o_alu_s1      (alu_s1),
      .o_alu_s2      (alu_s2),
      .i_alu_res     (alu_res),
      .i_alu_cond_hit(alu_cond),
      .i_alu_overflow(alu_ovf),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_ready),
      .o_rsp_res     (rsp_res),
      .o_rsp_cond_hit(rsp_cond),
      .o_rsp_overflow(rsp_ovf),
      .o_rsp_id      (rsp_id),
      .o_rsp_tag     (rsp_tag)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp_zero(input string tag);
      check({tag, "_valid"}, 64'(rsp_valid), 64'd0);
      check({tag, "_res"},   rsp_res,        64'd0);
      check({tag, "_tag"},   64'(rsp_tag),   64'd0);
      check({tag, "_id"},    64'(rsp_id),    64'd0);
      check({tag, "_ovf"},   64'(rsp_ovf),   64'd0);
      check({tag, "_cond"},  64'(rsp_cond),  64'd0);
   endtask

   initial begin
      logic       exp1;
      int         first;
      logic [63:0] exp_res [2];
      logic [3:0]  exp_tag [2];
      logic        exp_ovf [2];
      logic        exp_cond[2];

      rst = 1'b1; rsp_ready = 1'b0;
      v0 = 1'b1; op0 = ALU_ADD; s10 = 64'd1; s20 = 64'd1; tag0 = 4'd1;
      v1 = 1'b1; op1 = ALU_SUB; s11 = 64'd2; s21 = 64'd1; tag1 = 4'd1;

      // Reset with both requesters pushing.
      repeat (2) begin
         tick();
         check("rst_rdy0", 64'(rdy0), 64'd0);
         check("rst_rdy1", 64'(rdy1), 64'd0);
         check("rst_alu_s1", alu_s1, 64'd0);
         check_rsp_zero("rst_rsp");
      end

      // Single issue on port 0.
      rst = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
      op0 = ALU_ADD; s10 = 64'd5; s20 = 64'd3; tag0 = 4'd2;
      #1;
      check("single_rdy0", 64'(rdy0), 64'd1);
      check("single_rdy1", 64'(rdy1), 64'd0);
      check("single_alu_s1", alu_s1, 64'd5);
      tick();
      check("single_valid", 64'(rsp_valid), 64'd1);
      check("single_res",   rsp_res,        64'd8);
      check("single_id",    64'(rsp_id),    64'd0);
      check("single_tag",   64'(rsp_tag),   64'd2);
      check("single_ovf",   64'(rsp_ovf),   64'd0);

      // Tie: both valid every cycle. In RR mode the single issue above already
      // moved the pointer to port 1, so the tie starts with port 1.
      v0 = 1'b1; v1 = 1'b1;
      op1 = ALU_ADD; s11 = 64'd1000; s21 = 64'd1; tag1 = 4'd9;
      for (int i = 0; i < 8; i++) begin
         op0 = ALU_ADD; s10 = 64'(i); s20 = 64'd100; tag0 = 4'(i);
         #1;
`ifdef CH0RE_ALU_SCHED_RR_EN
         exp1 = ((i + 1) % 2) == 1;
`else
         exp1 = (i == 7);
`endif
         check("tie_rdy1", 64'(rdy1), 64'(exp1));
         check("tie_rdy0", 64'(rdy0), 64'(!exp1));
         tick();
         check("tie_id",  64'(rsp_id),  64'(exp1));
         check("tie_tag", 64'(rsp_tag), exp1 ? 64'd9 : 64'(i));
         check("tie_res", rsp_res, exp1 ? 64'd1001 : 64'(i + 100));
      end

      // Backpressure: one accept, then hold the response for 5 cycles.
      v1 = 1'b0;
      op0 = ALU_ADD; s10 = 64'd10; s20 = 64'd20; tag0 = 4'd3;
      tick();
      check("bp_first_res", rsp_res, 64'd30);
      rsp_ready = 1'b0;
      v0 = 1'b1; op0 = ALU_ADD; s10 = 64'd1; s20 = 64'd1; tag0 = 4'd4;
      v1 = 1'b1; op1 = ALU_SUB; s11 = 64'd0; s21 = 64'd1; tag1 = 4'd5;
      repeat (5) begin
         #1;
         check("bp_rdy0", 64'(rdy0), 64'd0);
         check("bp_rdy1", 64'(rdy1), 64'd0);
         tick();
         check("bp_valid", 64'(rsp_valid), 64'd1);
         check("bp_res",   rsp_res,        64'd30);
         check("bp_tag",   64'(rsp_tag),   64'd3);
      end

      // Release: drain and accept in the same cycle, then the other port.
      exp_res[0] = 64'd2;                 exp_tag[0] = 4'd4; exp_ovf[0] = 1'b0; exp_cond[0] = 1'b0;
      exp_res[1] = 64'hFFFF_FFFF_FFFF_FFFF; exp_tag[1] = 4'd5; exp_ovf[1] = 1'b1; exp_cond[1] = 1'b1;
`ifdef CH0RE_ALU_SCHED_RR_EN
      first = 1;
`else
      first = 0;
`endif
      rsp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         int p;
         p = (k == 0) ? first : 1 - first;
         #1;
         check("rel_rdy", 64'(rdy[p]), 64'd1);
         check("rel_rdy_other", 64'(rdy[1-p]), 64'd0);
         tick();
         check("rel_valid", 64'(rsp_valid), 64'd1);
         check("rel_id",    64'(rsp_id),    64'(p));
         check("rel_res",   rsp_res,        exp_res[p]);
         check("rel_tag",   64'(rsp_tag),   64'(exp_tag[p]));
         check("rel_ovf",   64'(rsp_ovf),   64'(exp_ovf[p]));
         check("rel_cond",  64'(rsp_cond),  64'(exp_cond[p]));
         if (p == 0) v0 = 1'b0; else v1 = 1'b0;
      end

      // Reset mid-operation discards a held response.
      v0 = 1'b1; op0 = ALU_ADD; s10 = 64'd7; s20 = 64'd7; tag0 = 4'd6;
      tick();
      check("mid_valid", 64'(rsp_valid), 64'd1);
      check("mid_res",   rsp_res,        64'd14);
      v0 = 1'b0; rsp_ready = 1'b0;
      tick();
      check("mid_hold_valid", 64'(rsp_valid), 64'd1);
      check("mid_hold_res",   rsp_res,        64'd14);
      rst = 1'b1; v0 = 1'b1;
      #1;
      check("mid_rst_rdy0", 64'(rdy0), 64'd0);
      tick();
      check_rsp_zero("mid_rst_rsp");
      rst = 1'b0; v0 = 1'b0;
      tick();
      check("mid_after_valid", 64'(rsp_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
